// File: rtl/plt_tree_pipe.sv
// Programmable LUT tree: a K-ary tree of K-input LUTs reduces N inputs to one bit.
// Holds serial/parallel configuration, readback, and a pipelined evaluation path with valid tracking.

module plt_lut #(
  parameter int K = 2
) (
  input  logic [(1<<K)-1:0] cfg,
  input  logic [K-1:0]      sel,
  output logic              y
);
  assign y = cfg[sel];
endmodule

module plt_tree_pipe #(
  parameter  int N        = 8,
  parameter  int K        = 2,
  parameter  int PIPE     = 1,
  localparam int NUM_LUTS = (N - 1) / (K - 1),
  localparam int ENT      = 1 << K,
  localparam int CFG_W    = NUM_LUTS * ENT
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic [1:0]       mode,
  input  logic             cfg_in,
  input  logic             cfg_valid,
  input  logic [CFG_W-1:0] scan_in,
  input  logic             scan_enable,
  input  logic [N-1:0]     data_in,
  input  logic             in_valid,
  output logic             out,
  output logic             out_valid,
  output logic             cfg_done,
  output logic [CFG_W-1:0] scan_out,
  output logic             rb_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    M_CFG  = 2'b00,
    M_USE  = 2'b01,
    M_TEST = 2'b10,
    M_LOAD = 2'b11
  } mode_e;

  function automatic int calc_levels(input int n, input int k);
    int l;
    int p;
    l = 0;
    p = 1;
    while (p < n) begin
      p = p * k;
      l++;
    end
    return l;
  endfunction

  // LUT index of the first LUT at tree level lv (level 0 starts at 0).
  function automatic int lvl_base(input int n, input int k, input int lv);
    int b;
    int c;
    b = 0;
    c = n / k;
    for (int i = 0; i < lv; i++) begin
      b += c;
      c = c / k;
    end
    return b;
  endfunction

  function automatic int lvl_cnt(input int n, input int k, input int lv);
    int c;
    c = n / k;
    for (int i = 0; i < lv; i++) c = c / k;
    return c;
  endfunction

  localparam int LEVELS = calc_levels(N, K);
  localparam int LAT    = (PIPE != 0) ? LEVELS : 1;
  localparam int STAGES = LAT - 1;
  localparam int PTR_W  = $clog2(CFG_W);
  localparam int SRC_W  = (NUM_LUTS > 1) ? NUM_LUTS - 1 : 1;

  logic [CFG_W-1:0] shadow, active, shifted;
  logic [PTR_W-1:0] cnt, ptr;
  logic             accept;
  logic [STAGES:0]  vld_pipe;
  logic [NUM_LUTS-1:0] node;
  logic [SRC_W-1:0] src;

  assign shifted = {shadow[CFG_W-2:0], cfg_in};
  assign accept  = (mode == M_USE) && in_valid;

  // Shadow collects serial bits; active only changes on a full-length commit or parallel load.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      shadow   <= '0;
      active   <= '0;
      cnt      <= '0;
      cfg_done <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      if (mode == M_CFG && cfg_valid) begin
        shadow <= shifted;
        if (cnt == PTR_W'(CFG_W - 1)) begin
          active   <= shifted;
          cnt      <= '0;
          cfg_done <= 1'b1;
        end else begin
          cnt <= cnt + PTR_W'(1);
        end
      end else if (mode == M_LOAD && scan_enable) begin
        shadow   <= scan_in;
        active   <= scan_in;
        cnt      <= '0;
        cfg_done <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      ptr      <= '0;
      scan_out <= '0;
      rb_out   <= 1'b0;
    end else if (mode == M_TEST) begin
      if (scan_enable) begin
        scan_out <= active;
      end else begin
        rb_out <= active[PTR_W'(CFG_W - 1) - ptr];
        ptr    <= (ptr == PTR_W'(CFG_W - 1)) ? '0 : ptr + PTR_W'(1);
      end
    end else begin
      ptr <= '0;
    end
  end

  // Valid tracking runs in every mode so in-flight vectors always drain.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      for (int i = 1; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign out_valid = vld_pipe[STAGES];
  assign busy      = |vld_pipe;

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int BASE  = lvl_base(N, K, l);
    localparam int PBASE = (l == 0) ? 0 : lvl_base(N, K, l - 1);
    localparam int CNT   = lvl_cnt(N, K, l);
    for (genvar j = 0; j < CNT; j++) begin : g_lut
      logic [K-1:0] sel;
      if (l == 0) begin : g_leaf
        assign sel = data_in[K*j +: K];
      end else begin : g_inner
        assign sel = src[PBASE + K*j +: K];
      end
      plt_lut #(.K(K)) u_lut (
        .cfg (active[(BASE + j)*ENT +: ENT]),
        .sel (sel),
        .y   (node[BASE + j])
      );
    end
  end

  if (PIPE != 0) begin : g_pipe
    logic [NUM_LUTS-1:0] node_q, lut_en;

    // Each level's registers load when the vector entering that level is valid.
    for (genvar l = 0; l < LEVELS; l++) begin : g_en
      localparam int BASE = lvl_base(N, K, l);
      localparam int CNT  = lvl_cnt(N, K, l);
      if (l == 0) begin : g_first
        assign lut_en[BASE +: CNT] = {CNT{accept}};
      end else begin : g_next
        assign lut_en[BASE +: CNT] = {CNT{vld_pipe[l-1]}};
      end
    end

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
        node_q <= '0;
      end else begin
        for (int i = 0; i < NUM_LUTS; i++)
          if (lut_en[i]) node_q[i] <= node[i];
      end
    end

    assign src = node_q[SRC_W-1:0];
    assign out = node_q[NUM_LUTS-1];
  end else begin : g_comb
    logic out_q;

    always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n)    out_q <= 1'b0;
      else if (accept) out_q <= node[NUM_LUTS-1];
    end

    assign src = node[SRC_W-1:0];
    assign out = out_q;
  end

endmodule
